// File: rtl/seq_param_alu_if.sv
// seq_param_alu_if: operand/result handshake bundle for seq_param_alu.
//   in_valid/in_ready : operation handshake (op, a, b qualified by in_valid)
//   out_valid/out_ready : result handshake (result, eq, gt, lt, err)
//   master modport : operand source / result consumer side
//   slave modport  : ALU side
interface seq_param_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 eq;
  logic                 gt;
  logic                 lt;
  logic                 err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, eq, gt, lt, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, eq, gt, lt, err
  );
endinterface

// File: rtl/seq_param_alu.sv
// seq_param_alu: clocked WIDTH-bit ALU with valid/ready handshakes.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_param_alu_if slave modport
//           op 000 ADD, 001 SUB, 010 CMP, 011 AND, 100 OR, 101 XOR,
//              110 MUL (shift-add, WIDTH+1 busy cycles), 111 reserved (err=1)
//           result is zero-extended to 2*WIDTH; eq/gt/lt valid for CMP only.
module seq_param_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_param_alu_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_CMP = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_MUL = 3'b110,
    OP_RSV = 3'b111
  } op_e;

  state_e               state_q, state_d;
  op_e                  op_in;
  logic                 in_ready_c;
  logic                 out_valid_c;
  logic                 accept;

  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [2*WIDTH-1:0]   result_q;
  logic                 eq_q, gt_q, lt_q, err_q;

  logic [2*WIDTH-1:0]   res_c;
  logic                 eq_c, gt_c, lt_c, err_c;

  assign op_in  = op_e'(bus.op);
  assign accept = bus.in_valid && in_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = (op_in == OP_MUL) ? BUSY : DONE;
      end
      BUSY: begin
        if (cnt_q == CNT_DONE) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          in_ready_c = 1'b1;
          if (bus.in_valid) state_d = (op_in == OP_MUL) ? BUSY : DONE;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle result, computed from the live inputs and registered on accept.
  always_comb begin
    res_c = '0;
    eq_c  = 1'b0;
    gt_c  = 1'b0;
    lt_c  = 1'b0;
    err_c = 1'b0;
    case (op_in)
      OP_ADD: res_c[WIDTH:0] = {1'b0, bus.a} + {1'b0, bus.b};
      // Carry out of a + ~b + 1 is the no-borrow flag (a >= b).
      OP_SUB: res_c[WIDTH:0] = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
      OP_CMP: begin
        eq_c = (bus.a == bus.b);
        gt_c = (bus.a >  bus.b);
        lt_c = (bus.a <  bus.b);
      end
      OP_AND: res_c[WIDTH-1:0] = bus.a & bus.b;
      OP_OR:  res_c[WIDTH-1:0] = bus.a | bus.b;
      OP_XOR: res_c[WIDTH-1:0] = bus.a ^ bus.b;
      OP_RSV: err_c = 1'b1;
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      if (op_in == OP_MUL) begin
        acc_q    <= '0;
        mcand_q  <= (2*WIDTH)'(bus.a);
        mplier_q <= bus.b;
        cnt_q    <= '0;
      end else begin
        result_q <= res_c;
        eq_q     <= eq_c;
        gt_q     <= gt_c;
        lt_q     <= lt_c;
        err_q    <= err_c;
      end
    end else if (state_q == BUSY) begin
      // WIDTH iterations, then one extra cycle to move the accumulator out.
      if (cnt_q == CNT_DONE) begin
        result_q <= acc_q;
        eq_q     <= 1'b0;
        gt_q     <= 1'b0;
        lt_q     <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;
  assign bus.eq        = eq_q;
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign bus.err       = err_q;
endmodule
